// File: rtl/regfile_sched_pkg.sv
// regfile_sched_pkg: shared types and helpers for the register-file port scheduler
package regfile_sched_pkg;
  typedef enum logic [1:0] {IDLE, MOV_READ, MOV_WRITE} sched_state_t;
  typedef enum logic {OP_WRITE = 1'b0, OP_MOV = 1'b1} sched_op_t;
  function automatic int pc_index(int regs);
    return regs - 1;
  endfunction
  localparam int PC_INDEX = pc_index(16);
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first valid requester at or after rr_ptr
module rr_arbiter #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] valid,
  input  logic [W-1:0] rr_ptr,
  output logic [N-1:0] grant,
  output logic [W-1:0] id,
  output logic         any_valid
);
  logic found;
  assign any_valid = |valid;
  always_comb begin
    grant = '0;
    id = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++)
      if (!found && valid[(int'(rr_ptr) + i) % N]) begin
        found = 1'b1;
        grant[(int'(rr_ptr) + i) % N] = 1'b1;
        id = W'((int'(rr_ptr) + i) % N);
      end
  end
endmodule

// File: rtl/regfile_port_scheduler.sv
// regfile_port_scheduler: round-robin sharing of one bank write port and one read port,
// with two-cycle MOV sequencing and PC write protection
module regfile_port_scheduler import regfile_sched_pkg::*; #(
  parameter int NumRequesters     = 4,
  parameter int RegisterSize      = 32,
  parameter int AmountOfRegisters = 16,
  parameter int IndexWidth        = 4
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [NumRequesters-1:0]              req_valid,
  output logic [NumRequesters-1:0]              req_ready,
  input  logic [NumRequesters-1:0]              req_op,
  input  logic [NumRequesters*IndexWidth-1:0]   req_dst,
  input  logic [NumRequesters*IndexWidth-1:0]   req_src,
  input  logic [NumRequesters*RegisterSize-1:0] req_data,
  output logic                                  rf_write_en,
  output logic [IndexWidth-1:0]                 rf_write_reg,
  output logic [RegisterSize-1:0]               rf_write_value,
  output logic [IndexWidth-1:0]                 rf_read_reg,
  input  logic [RegisterSize-1:0]               rf_read_value,
  output logic                                  done_valid,
  output logic [$clog2(NumRequesters)-1:0]      done_id,
  output logic                                  err_pc_write
);
  localparam int IdW = $clog2(NumRequesters);
  localparam logic [IndexWidth-1:0] PcIdx = IndexWidth'(pc_index(AmountOfRegisters));
  sched_state_t state_q, state_d;
  logic [IdW-1:0] rr_q, rr_d, id_q, id_d, did_q, did_d, win_id;
  logic [IndexWidth-1:0] dst_q, dst_d, wreg_q, wreg_d, rreg_q, rreg_d, sel_dst, sel_src;
  logic [RegisterSize-1:0] wval_q, wval_d, sel_data;
  logic we_q, we_d, dv_q, dv_d, err_q, err_d, any_valid, reject;
  logic [NumRequesters-1:0] grant;
  rr_arbiter #(.N(NumRequesters)) u_arb (
    .valid(req_valid), .rr_ptr(rr_q), .grant(grant), .id(win_id), .any_valid(any_valid)
  );
  assign sel_dst = req_dst[win_id*IndexWidth +: IndexWidth];
  assign sel_src = req_src[win_id*IndexWidth +: IndexWidth];
  assign sel_data = req_data[win_id*RegisterSize +: RegisterSize];
  assign reject = sel_dst == PcIdx && win_id != '0;
  // Grant is combinational so a WRITE can be accepted every cycle while idle
  assign req_ready = (state_q == IDLE && !reset) ? grant : '0;
  assign rf_write_en = we_q;
  assign rf_write_reg = wreg_q;
  assign rf_write_value = wval_q;
  assign rf_read_reg = rreg_q;
  assign done_valid = dv_q;
  assign done_id = did_q;
  assign err_pc_write = err_q;
  always_comb begin
    state_d = state_q;
    rr_d = rr_q;
    id_d = id_q;
    dst_d = dst_q;
    wreg_d = wreg_q;
    wval_d = wval_q;
    rreg_d = rreg_q;
    did_d = did_q;
    we_d = 1'b0;
    dv_d = 1'b0;
    err_d = 1'b0;
    case (state_q)
      IDLE: if (any_valid) begin
        rr_d = win_id == IdW'(NumRequesters - 1) ? '0 : win_id + 1'b1;
        id_d = win_id;
        dst_d = sel_dst;
        did_d = reject || sched_op_t'(req_op[win_id]) == OP_WRITE ? win_id : did_q;
        dv_d = reject || sched_op_t'(req_op[win_id]) == OP_WRITE;
        err_d = reject;
        if (!reject && sched_op_t'(req_op[win_id]) == OP_MOV) begin
          state_d = MOV_READ;
          rreg_d = sel_src;
        end else if (!reject) begin
          we_d = 1'b1;
          wreg_d = sel_dst;
          wval_d = sel_data;
        end
      end
      MOV_READ: state_d = MOV_WRITE;
      MOV_WRITE: begin
        state_d = IDLE;
        we_d = 1'b1;
        wreg_d = dst_q;
        wval_d = rf_read_value;
        dv_d = 1'b1;
        did_d = id_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      rr_q <= '0;
      id_q <= '0;
      dst_q <= '0;
      wreg_q <= '0;
      wval_q <= '0;
      rreg_q <= '0;
      did_q <= '0;
      we_q <= 1'b0;
      dv_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q <= rr_d;
      id_q <= id_d;
      dst_q <= dst_d;
      wreg_q <= wreg_d;
      wval_q <= wval_d;
      rreg_q <= rreg_d;
      did_q <= did_d;
      we_q <= we_d;
      dv_q <= dv_d;
      err_q <= err_d;
    end
endmodule
